// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock/restart inputs and reset/status outputs of the
// PLL reset sequencer. The master modport is the sequencer side. The slave
// modport is the side that supplies the lock flag and consumes the domain resets.
interface pll_reset_sequencer_if #(
  parameter int NUM_STAGES   = 3,
  parameter int LOSS_COUNT_W = 8
);
  logic                    pll_lock_in;
  logic                    sw_restart_in;
  logic [NUM_STAGES-1:0]   stage_reset_out;
  logic                    ready_out;
  logic [2:0]              state_out;
  logic [LOSS_COUNT_W-1:0] loss_count_out;
  logic                    timeout_out;

  modport master (
    input  pll_lock_in,
    input  sw_restart_in,
    output stage_reset_out,
    output ready_out,
    output state_out,
    output loss_count_out,
    output timeout_out
  );

  modport slave (
    output pll_lock_in,
    output sw_restart_in,
    input  stage_reset_out,
    input  ready_out,
    input  state_out,
    input  loss_count_out,
    input  timeout_out
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: waits for a stable PLL lock and then releases the PLL-fed
// reset domains one at a time, in index order and STAGE_GAP cycles apart.
// A lock loss or a software restart re-asserts every reset and restarts the
// sequence. The block runs on the free-running reference clock, so it keeps
// working while the PLL is unlocked.
// Build option: define PLL_SEQ_TIMEOUT_EN to add the sticky lock-acquire timeout.
// When the macro is undefined, timeout_out is tied low.
module pll_reset_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int LOSS_COUNT_W   = 8
) (
  input logic                   clock_in,
  input logic                   reset_in,
  pll_reset_sequencer_if.master bus
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = $clog2(NUM_STAGES + 1);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_ALL     = IW'(NUM_STAGES);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_t;

  if (NUM_STAGES < 1 || STABLE_CYCLES < 1 || STAGE_GAP < 1 ||
      TIMEOUT_CYCLES < 1 || LOSS_COUNT_W < 1) begin : g_badParams
    $error("pll_reset_sequencer: size parameters must all be at least 1");
  end

  logic                    r_lockMeta;
  logic                    r_lockSync;
  state_t                  r_state;
  logic [SW-1:0]           r_stableCnt;
  logic [GW-1:0]           r_gapCnt;
  logic [IW-1:0]           r_stageIdx;
  logic [NUM_STAGES-1:0]   r_stageReset;
  logic                    r_ready;
  logic [LOSS_COUNT_W-1:0] r_lossCnt;

  logic                    w_lockS;
  state_t                  w_nextState;
  logic [SW-1:0]           w_stableCntNext;
  logic [GW-1:0]           w_gapCntNext;
  logic [IW-1:0]           w_stageIdxNext;
  logic                    w_lossEvent;
  logic [NUM_STAGES-1:0]   w_stageResetNext;

  assign w_lockS = r_lockSync;

  // Two-flop synchronizer bringing the asynchronous lock flag into the reference clock domain
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_lockMeta <= 1'b0;
      r_lockSync <= 1'b0;
    end else begin
      r_lockMeta <= bus.pll_lock_in;
      r_lockSync <= r_lockMeta;
    end
  end

  // Next-state, counter and registered-output decode; a restart overrides everything except reset
  always_comb begin
    w_nextState      = r_state;
    w_stableCntNext  = r_stableCnt;
    w_gapCntNext     = r_gapCnt;
    w_stageIdxNext   = r_stageIdx;
    w_lossEvent      = 1'b0;
    w_stageResetNext = '1;

    case (r_state)
      WAIT_LOCK: begin
        if (w_lockS) begin
          w_nextState     = STABLE;
          w_stableCntNext = '0;
        end
      end
      STABLE: begin
        if (!w_lockS) begin
          w_nextState = WAIT_LOCK;
        end else if (r_stableCnt == STABLE_LAST) begin
          w_nextState    = RELEASE;
          w_gapCntNext   = '0;
          w_stageIdxNext = IW'(1);
        end else begin
          w_stableCntNext = r_stableCnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!w_lockS) begin
          w_lossEvent  = 1'b1;
          w_nextState  = LOST;
          w_gapCntNext = '0;
        end else if (r_stageIdx == IDX_ALL) begin
          w_nextState = RUN;
        end else if (r_gapCnt == GAP_LAST) begin
          w_stageIdxNext = r_stageIdx + 1'b1;
          w_gapCntNext   = '0;
        end else begin
          w_gapCntNext = r_gapCnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lockS) begin
          w_lossEvent  = 1'b1;
          w_nextState  = LOST;
          w_gapCntNext = '0;
        end
      end
      LOST: begin
        if (r_gapCnt == GAP_LAST) begin
          w_nextState = WAIT_LOCK;
        end else begin
          w_gapCntNext = r_gapCnt + 1'b1;
        end
      end
      default: begin
        w_nextState  = LOST;
        w_gapCntNext = '0;
      end
    endcase

    if (bus.sw_restart_in) begin
      w_nextState  = LOST;
      w_gapCntNext = '0;
    end

    if (w_nextState == RUN) begin
      w_stageResetNext = '0;
    end else if (w_nextState == RELEASE) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        w_stageResetNext[k] = (k >= int'(w_stageIdxNext));
      end
    end
  end

  // State, sequencing counters and registered outputs; the loss counter saturates at all-ones
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state      <= WAIT_LOCK;
      r_stableCnt  <= '0;
      r_gapCnt     <= '0;
      r_stageIdx   <= '0;
      r_stageReset <= '1;
      r_ready      <= 1'b0;
      r_lossCnt    <= '0;
    end else begin
      r_state      <= w_nextState;
      r_stableCnt  <= w_stableCntNext;
      r_gapCnt     <= w_gapCntNext;
      r_stageIdx   <= w_stageIdxNext;
      r_stageReset <= w_stageResetNext;
      r_ready      <= (w_nextState == RUN);
      if (w_lossEvent && (r_lossCnt != '1)) begin
        r_lossCnt <= r_lossCnt + 1'b1;
      end
    end
  end

  assign bus.stage_reset_out = r_stageReset;
  assign bus.ready_out       = r_ready;
  assign bus.state_out       = r_state;
  assign bus.loss_count_out  = r_lossCnt;

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timeoutCnt;
  logic          r_timeout;

  // Time WAIT_LOCK/STABLE since the last clean start; a STABLE bounce keeps the count
  always_ff @(posedge clock_in) begin
    if (reset_in || bus.sw_restart_in) begin
      r_timeoutCnt <= '0;
      r_timeout    <= 1'b0;
    end else if (r_state == LOST) begin
      r_timeoutCnt <= '0;
    end else if (!r_timeout && (r_state == WAIT_LOCK || r_state == STABLE)) begin
      r_timeoutCnt <= r_timeoutCnt + 1'b1;
      if (r_timeoutCnt == TIMEOUT_LAST) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.timeout_out = r_timeout;
`else
  assign bus.timeout_out = 1'b0;
`endif

endmodule
